// File: rtl/axi4_mem_arbiter.sv
// Round-robin burst arbiter: one master owns the AXI4 slave per burst.
// Optional forced release on idle bursts when ARB_TIMEOUT_EN is defined.
module axi4_mem_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_len,
   input  logic                 beat_hs,
   output logic [NUM_REQ-1:0]   grant,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 stray_beat,
   output logic                 timeout
);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
   localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NUM_REQ - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_REQ-1:0]  r_grant;
   logic [ID_W-1:0]     r_grant_id;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [7:0]          r_beats_left;
   logic                r_busy;
   logic                r_stray;
   logic                r_timeout;

   logic                w_found;
   logic [ID_W-1:0]     w_winner;
   logic                w_last_beat;
   logic                w_to_hit;
   logic                w_release;
   logic [ID_W-1:0]     w_rr_nxt;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_found)   w_state_nxt = S_BURST;
         S_BURST: if (w_release) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Search starts at rr_ptr and wraps at NUM_REQ, so unused indices never win.
   always_comb begin
      int idx;
      idx      = 0;
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && req[idx]) begin
            w_found  = 1'b1;
            w_winner = ID_W'(idx);
         end
      end
   end

   always_comb begin
      w_last_beat = (r_state == S_BURST) && beat_hs && (r_beats_left == 8'd0);
      w_release   = w_last_beat || w_to_hit;
      w_rr_nxt    = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TO_W-1:0] r_to_cnt;

   assign w_to_hit = (r_state == S_BURST) && !beat_hs &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)                              r_to_cnt <= '0;
      else if (r_state != S_BURST || beat_hs) r_to_cnt <= '0;
      else if (w_to_hit)                       r_to_cnt <= '0;
      else                                     r_to_cnt <= r_to_cnt + 1'b1;
   end
`else
   logic w_unused_to;

   assign w_to_hit    = 1'b0;
   assign w_unused_to = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_grant      <= '0;
         r_grant_id   <= '0;
         r_rr_ptr     <= '0;
         r_beats_left <= '0;
         r_busy       <= 1'b0;
         r_stray      <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_stray   <= (r_state == S_IDLE) && beat_hs;
         r_timeout <= w_to_hit;
         if (r_state == S_IDLE) begin
            if (w_found) begin
               r_grant      <= ONE_HOT0 << w_winner;
               r_grant_id   <= w_winner;
               r_busy       <= 1'b1;
               r_beats_left <= req_len[8*int'(w_winner) +: 8];
            end
         end else if (w_release) begin
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_beats_left <= '0;
            r_rr_ptr     <= w_rr_nxt;
         end else if (beat_hs && r_beats_left != 8'd0) begin
            r_beats_left <= r_beats_left - 8'd1;
         end
      end
   end

   assign grant      = r_grant;
   assign grant_id   = r_grant_id;
   assign busy       = r_busy;
   assign stray_beat = r_stray;
   assign timeout    = r_timeout;

endmodule
